// File: rtl/clk_en_gen_pkg.sv
// Shared definitions for the multi-channel clock-enable generator:
// the per-channel state encoding and the default field widths.
package clk_en_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PHASE = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } chan_state_t;

  localparam int DEF_DIV_W = 8;
  localparam int DEF_CNT_W = 5;

endpackage

// File: rtl/clk_en_chan.sv
// One clock-enable channel: FSM, phase counter, period counter and,
// when CLK_EN_GEN_BURST_EN is defined, the burst pulse counter.
// The edge that latches the parameters is count 1 of the first interval,
// so the first pulse is registered on edge phase+div after the start edge.
module clk_en_chan
  import clk_en_gen_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  input  logic [CNT_W-1:0] burst_len,
  output logic             clk_en,
  output logic             busy,
  output logic             done
);

  chan_state_t      state, state_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [DIV_W-1:0] phase_q, phase_n;
  logic [DIV_W-1:0] per_cnt, per_n, per_base, per_next;
  logic [DIV_W-1:0] ph_cnt, ph_n;
  logic             tick;
  logic             en_n, busy_n, done_n;

`ifdef CLK_EN_GEN_BURST_EN
  logic [CNT_W-1:0] burst_q, burst_n;
  logic [CNT_W-1:0] pulse_cnt, pc_n, pc_inc;
`else
  logic unused_burst;
  assign unused_burst = ^burst_len;
`endif

  // Next-state, counter and registered-output computation for the channel
  always_comb begin
    state_n  = state;
    div_n    = div_q;
    phase_n  = phase_q;
    per_n    = per_cnt;
    ph_n     = ph_cnt;
    per_base = '0;
    tick     = 1'b0;
    en_n     = 1'b0;
    done_n   = 1'b0;
`ifdef CLK_EN_GEN_BURST_EN
    burst_n  = burst_q;
    pc_n     = pulse_cnt;
    pc_inc   = '0;
`endif

    case (state)
      IDLE: begin
        if (start && (div != '0)) begin
          div_n   = div;
          phase_n = phase;
`ifdef CLK_EN_GEN_BURST_EN
          burst_n = burst_len;
`endif
          if (phase != '0) begin
            state_n = PHASE;
            ph_n    = DIV_W'(1);
          end else begin
            state_n = RUN;
            tick    = 1'b1;
          end
        end
      end
      PHASE: begin
        if (start) begin
          if (ph_cnt == phase_q) begin
            state_n = RUN;
            ph_n    = '0;
            tick    = 1'b1;
          end else begin
            ph_n = ph_cnt + DIV_W'(1);
          end
        end
      end
      RUN: begin
        if (start) begin
          tick     = 1'b1;
          per_base = per_cnt;
        end
      end
      DONE: begin
        if (!start) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    per_next = per_base + DIV_W'(1);
    if (tick) begin
      if (per_next == div_n) begin
        en_n  = 1'b1;
        per_n = '0;
`ifdef CLK_EN_GEN_BURST_EN
        pc_inc = pulse_cnt + CNT_W'(1);
        if ((burst_n != '0) && (pc_inc == burst_n)) begin
          done_n  = 1'b1;
          state_n = DONE;
          pc_n    = '0;
        end else begin
          pc_n = pc_inc;
        end
`endif
      end else begin
        per_n = per_next;
      end
    end

    if (clear) begin
      state_n = IDLE;
      per_n   = '0;
      ph_n    = '0;
      en_n    = 1'b0;
      done_n  = 1'b0;
`ifdef CLK_EN_GEN_BURST_EN
      pc_n    = '0;
`endif
    end

    busy_n = (state_n == PHASE) || (state_n == RUN) || done_n;
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_q     <= '0;
      phase_q   <= '0;
      per_cnt   <= '0;
      ph_cnt    <= '0;
      clk_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef CLK_EN_GEN_BURST_EN
      burst_q   <= '0;
      pulse_cnt <= '0;
`endif
    end else begin
      state     <= state_n;
      div_q     <= div_n;
      phase_q   <= phase_n;
      per_cnt   <= per_n;
      ph_cnt    <= ph_n;
      clk_en    <= en_n;
      busy      <= busy_n;
      done      <= done_n;
`ifdef CLK_EN_GEN_BURST_EN
      burst_q   <= burst_n;
      pulse_cnt <= pc_n;
`endif
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel programmable clock-enable generator top level.
// Slices the parameter buses per channel and fans out clk/reset/clear.
// Optional burst mode is enabled with the CLK_EN_GEN_BURST_EN macro.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = DEF_DIV_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH*DIV_W-1:0] div,
  input  logic [NUM_CH*DIV_W-1:0] phase,
  input  logic [NUM_CH*CNT_W-1:0] burst_len,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_en_chan #(
      .DIV_W(DIV_W),
      .CNT_W(CNT_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .start    (start[i]),
      .div      (div[i*DIV_W +: DIV_W]),
      .phase    (phase[i*DIV_W +: DIV_W]),
      .burst_len(burst_len[i*CNT_W +: CNT_W]),
      .clk_en   (clk_en[i]),
      .busy     (busy[i]),
      .done     (done[i])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen. A reference model counts the
// edges on which each channel is active and derives pulses arithmetically:
// a pulse is due on active edge n when n > phase and (n - phase) % div == 0.
module tb_clk_en_gen;

  localparam int NUM_CH = 2;
  localparam int DIV_W  = 8;
  localparam int CNT_W  = 5;
`ifdef CLK_EN_GEN_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset, clear;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH*DIV_W-1:0] div, phase;
  logic [NUM_CH*CNT_W-1:0] burst_len;
  logic [NUM_CH-1:0]       clk_en, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: mode 0 = idle, 1 = active, 2 = finished burst
  int   m_mode[NUM_CH];
  int   m_n[NUM_CH];
  int   m_pulses[NUM_CH];
  int   m_div[NUM_CH];
  int   m_phase[NUM_CH];
  int   m_burst[NUM_CH];
  logic exp_en[NUM_CH];
  logic exp_busy[NUM_CH];
  logic exp_done[NUM_CH];

  clk_en_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .start    (start),
    .div      (div),
    .phase    (phase),
    .burst_len(burst_len),
    .clk_en   (clk_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic modelEdge();
    for (int c = 0; c < NUM_CH; c++) begin
      exp_en[c]   = 1'b0;
      exp_done[c] = 1'b0;
      if (reset || clear) begin
        m_mode[c] = 0;
        m_n[c]    = 0;
      end else begin
        if (m_mode[c] == 0) begin
          if (start[c] && (div[c*DIV_W +: DIV_W] != 0)) begin
            m_div[c]    = int'(div[c*DIV_W +: DIV_W]);
            m_phase[c]  = int'(phase[c*DIV_W +: DIV_W]);
            m_burst[c]  = int'(burst_len[c*CNT_W +: CNT_W]);
            m_mode[c]   = 1;
            m_n[c]      = 0;
            m_pulses[c] = 0;
          end
        end else if (m_mode[c] == 2) begin
          if (!start[c]) m_mode[c] = 0;
        end
        if (m_mode[c] == 1 && start[c]) begin
          m_n[c]++;
          if (m_n[c] > m_phase[c] && ((m_n[c] - m_phase[c]) % m_div[c]) == 0) begin
            exp_en[c] = 1'b1;
            m_pulses[c]++;
            if (BURST && m_burst[c] != 0 && m_pulses[c] == m_burst[c]) begin
              exp_done[c] = 1'b1;
              m_mode[c]   = 2;
            end
          end
        end
      end
      exp_busy[c] = (m_mode[c] == 1) || exp_done[c];
    end
  endtask

  task automatic checkOutput();
    for (int c = 0; c < NUM_CH; c++) begin
      total++;
      assert (clk_en[c] === exp_en[c]) else begin
        bad++;
        $error("[TB] FAIL clk_en[%0d] cyc=%0d got=%b exp=%b", c, cyc, clk_en[c], exp_en[c]);
      end
      total++;
      assert (busy[c] === exp_busy[c]) else begin
        bad++;
        $error("[TB] FAIL busy[%0d] cyc=%0d got=%b exp=%b", c, cyc, busy[c], exp_busy[c]);
      end
      total++;
      assert (done[c] === exp_done[c]) else begin
        bad++;
        $error("[TB] FAIL done[%0d] cyc=%0d got=%b exp=%b", c, cyc, done[c], exp_done[c]);
      end
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      modelEdge();
      cyc++;
      #1;
      checkOutput();
    end
  endtask

  int pulse_seen;
  int exp_pulses;

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c] = 0; m_n[c] = 0; m_pulses[c] = 0;
      m_div[c] = 1; m_phase[c] = 0; m_burst[c] = 0;
    end
    reset = 1'b1; clear = 1'b0; start = '0;
    div = '0; phase = '0; burst_len = '0;
    #2;

    // reset state
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(2);

    // continuous div=4 on ch0, div=1 on ch1
    div = {8'd1, 8'd4}; phase = '0; burst_len = '0; start = 2'b11;
    applyStimulus(20);
    clear = 1'b1; start = 2'b00;
    applyStimulus(1);
    clear = 1'b0;

    // phase offset, then a 3-cycle pause on ch0
    div = {8'd4, 8'd4}; phase = {8'd2, 8'd0}; start = 2'b11;
    applyStimulus(9);
    start = 2'b10;
    applyStimulus(3);
    start = 2'b11;
    applyStimulus(12);
    clear = 1'b1; start = 2'b00;
    applyStimulus(1);
    clear = 1'b0;

    // burst of 16 at div=2, then restart
    div = {8'd0, 8'd2}; phase = '0; burst_len = {5'd0, 5'd16}; start = 2'b01;
    pulse_seen = 0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1);
      if (clk_en[0]) pulse_seen++;
    end
    exp_pulses = BURST ? 16 : 20;
    total++;
    assert (pulse_seen === exp_pulses) else begin
      bad++;
      $error("[TB] FAIL burst_count got=%0d exp=%0d", pulse_seen, exp_pulses);
    end
    start = 2'b00;
    applyStimulus(1);
    start = 2'b01;
    applyStimulus(6);

    // disabled channel
    clear = 1'b1; start = 2'b00;
    applyStimulus(1);
    clear = 1'b0;
    div = '0; start = 2'b11;
    applyStimulus(5);

    // clear together with start keeps the channels idle
    div = {8'd4, 8'd3}; clear = 1'b1; start = 2'b11;
    applyStimulus(1);
    clear = 1'b0; start = 2'b00;
    applyStimulus(2);

    // reset during PHASE
    div = {8'd3, 8'd3}; phase = {8'd10, 8'd10}; start = 2'b11;
    applyStimulus(3);
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0; start = 2'b00;
    applyStimulus(2);

    // randomized traffic, parameters also change while channels run
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        start[c] = ($urandom_range(0, 5) != 0);
        if ($urandom_range(0, 7) == 0) begin
          div[c*DIV_W +: DIV_W]       = DIV_W'($urandom_range(0, 5));
          phase[c*DIV_W +: DIV_W]     = DIV_W'($urandom_range(0, 4));
          burst_len[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 5));
        end
      end
      clear = ($urandom_range(0, 60) == 0);
      reset = ($urandom_range(0, 150) == 0);
      applyStimulus(1);
    end
    reset = 1'b0; clear = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
